// File: rtl/deserialize.sv
// Packs a stream of BIT_WIDTH-bit elements into one LENGTH*BIT_WIDTH word.
// The first accepted element of a word ends up in the top slot. A flush
// pulse zero-pads a partial word. The finished word is held until the
// consumer takes it.
module deserialize #(
  parameter int LENGTH    = 32,
  parameter int BIT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [BIT_WIDTH-1:0]          in,
  output logic                          in_ready,
  input  logic                          flush,
  output logic [LENGTH*BIT_WIDTH-1:0]   out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(LENGTH+1)-1:0]   count
);

  localparam int CW = $clog2(LENGTH + 1);
  localparam int WW = LENGTH * BIT_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   next_count;
  logic [WW-1:0]   next_out;
  logic            next_out_valid;
  logic [WW-1:0]   shifted;

  // Input is accepted only while collecting elements; depends on state alone.
  assign in_ready = (state == FILL);

  // Held word moved up one slot, leaving slot 0 free for the incoming element.
  assign shifted = out << BIT_WIDTH;

  // Next-state, word, count and valid computation.
  always_comb begin
    next_state     = state;
    next_count     = count;
    next_out       = out;
    next_out_valid = out_valid;
    case (state)
      FILL: begin
        if (in_valid) begin
          // Accept has priority over flush; the element is stored first.
          next_out                = shifted;
          next_out[BIT_WIDTH-1:0] = in;
          next_count              = count + ONE;
          if (count == LAST) begin
            next_state     = HOLD;
            next_out_valid = 1'b1;
          end else if (flush) begin
            next_state = PAD;
          end else begin
            next_state = FILL;
          end
        end else if (flush && (count != {CW{1'b0}})) begin
          next_state = PAD;
        end else begin
          next_state = FILL;
        end
      end
      PAD: begin
        // shifted already carries zeros in slot 0.
        next_out   = shifted;
        next_count = count + ONE;
        if (count == LAST) begin
          next_state     = HOLD;
          next_out_valid = 1'b1;
        end else begin
          next_state = PAD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          next_state     = FILL;
          next_count     = {CW{1'b0}};
          next_out_valid = 1'b0;
        end else begin
          next_state = HOLD;
        end
      end
      default: begin
        next_state     = FILL;
        next_count     = {CW{1'b0}};
        next_out       = {WW{1'b0}};
        next_out_valid = 1'b0;
      end
    endcase
  end

  // State, word, count and valid registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      count     <= {CW{1'b0}};
      out       <= {WW{1'b0}};
      out_valid <= 1'b0;
    end else begin
      state     <= next_state;
      count     <= next_count;
      out       <= next_out;
      out_valid <= next_out_valid;
    end
  end

endmodule
